// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states, port owner and the
// fixed access-size code used for instruction refills.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter. The slave modport is the
// arbiter's view; master is the view of the caches plus memory around it.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_req_i;
    logic [DATA_WIDTH-1:0] i_addr_i;
    logic [DATA_WIDTH-1:0] i_rdata_o;
    logic                  i_done_o;

    logic                  d_req_i;
    logic                  d_we_i;
    logic [DATA_WIDTH-1:0] d_addr_i;
    logic [DATA_WIDTH-1:0] d_wdata_i;
    logic [2:0]            d_funct3_i;
    logic [DATA_WIDTH-1:0] d_rdata_o;
    logic                  d_done_o;

    logic [DATA_WIDTH-1:0] mem_addr_o;
    logic                  mem_wr_en_o;
    logic [DATA_WIDTH-1:0] mem_wr_data_o;
    logic [2:0]            mem_funct3_o;
    logic [DATA_WIDTH-1:0] mem_rd_data_i;

    modport slave (
        input  i_req_i, i_addr_i,
        output i_rdata_o, i_done_o,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_funct3_i,
        output d_rdata_o, d_done_o,
        output mem_addr_o, mem_wr_en_o, mem_wr_data_o, mem_funct3_o,
        input  mem_rd_data_i
    );

    modport master (
        output i_req_i, i_addr_i,
        input  i_rdata_o, i_done_o,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_funct3_i,
        input  d_rdata_o, d_done_o,
        input  mem_addr_o, mem_wr_en_o, mem_wr_data_o, mem_funct3_o,
        output mem_rd_data_i
    );
endinterface

// File: rtl/mem_arb_pick.sv
// Grant selection between the instruction and data requesters.
// MEM_ARB_ROUND_ROBIN_EN: ties alternate against last_owner; otherwise D wins ties.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  arb_owner_t last_owner,
    output arb_owner_t o_owner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        o_owner = OWN_I;
        if (i_req && d_req) begin
            o_owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            o_owner = OWN_D;
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = last_owner;

    always_comb begin
        o_owner = d_req ? OWN_D : OWN_I;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one data_memory port between I-cache refill and D-cache miss handling.
// Optional MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking.
//
// state | meaning
// IDLE  | no access in flight, memory bus parked at zero
// BUSY  | bus driven from owner's inputs, cnt counts down to the capture cycle
// RESP  | owner's done pulses for one cycle with registered read data
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    mem_arbiter_if.slave bus
);

    localparam int                 CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(MEM_LATENCY - 1);

    arb_state_t            r_state;
    arb_owner_t            r_owner;
    arb_owner_t            r_last_owner;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_i_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;
    logic                  r_i_done;
    logic                  r_d_done;
    arb_owner_t            w_pick;
    logic                  w_last_cycle;

    mem_arb_pick u_pick (
        .i_req      (bus.i_req_i),
        .d_req      (bus.d_req_i),
        .last_owner (r_last_owner),
        .o_owner    (w_pick)
    );

    assign w_last_cycle = (r_state == BUSY) && (r_cnt == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_owner      <= OWN_I;
            r_last_owner <= OWN_I;
            r_cnt        <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_i_done     <= 1'b0;
            r_d_done     <= 1'b0;
        end else begin
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.i_req_i || bus.d_req_i) begin
                        r_owner <= w_pick;
                        r_cnt   <= CNT_INIT;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        // Read data is captured on writes too; callers ignore it.
                        if (r_owner == OWN_I) begin
                            r_i_rdata <= bus.mem_rd_data_i;
                            r_i_done  <= 1'b1;
                        end else begin
                            r_d_rdata <= bus.mem_rd_data_i;
                            r_d_done  <= 1'b1;
                        end
                        r_last_owner <= r_owner;
                        r_state      <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.mem_addr_o    = '0;
        bus.mem_wr_en_o   = 1'b0;
        bus.mem_wr_data_o = '0;
        bus.mem_funct3_o  = 3'b000;
        if (r_state == BUSY) begin
            if (r_owner == OWN_I) begin
                bus.mem_addr_o   = bus.i_addr_i;
                bus.mem_funct3_o = FUNCT3_WORD;
            end else begin
                bus.mem_addr_o    = bus.d_addr_i;
                bus.mem_funct3_o  = bus.d_funct3_i;
                bus.mem_wr_data_o = bus.d_wdata_i;
                // Single write strobe per access, on the capture cycle only.
                bus.mem_wr_en_o   = bus.d_we_i && w_last_cycle;
            end
        end
    end

    assign bus.i_rdata_o = r_i_rdata;
    assign bus.i_done_o  = r_i_done;
    assign bus.d_rdata_o = r_d_rdata;
    assign bus.d_done_o  = r_d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: three instances at latencies 2, 3 and 4,
// behavioural word memories, and a per-port scoreboard of expected read data.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk;
    logic rst;
    int   cyc;
    int   n_total;
    int   n_bad;

    logic [31:0] mem2 [256];
    logic [31:0] mem3 [256];
    logic [31:0] mem4 [256];

    logic [31:0] exp_i_q [$];
    logic [31:0] exp_d_q [$];
    arb_owner_t  lo_m;

    mem_arbiter_if #(.DATA_WIDTH(32)) ifc2 ();
    mem_arbiter_if #(.DATA_WIDTH(32)) ifc3 ();
    mem_arbiter_if #(.DATA_WIDTH(32)) ifc4 ();

    mem_arbiter #(.DATA_WIDTH(32), .MEM_LATENCY(2)) u2 (.clk_i(clk), .rst_i(rst), .bus(ifc2));
    mem_arbiter #(.DATA_WIDTH(32), .MEM_LATENCY(3)) u3 (.clk_i(clk), .rst_i(rst), .bus(ifc3));
    mem_arbiter #(.DATA_WIDTH(32), .MEM_LATENCY(4)) u4 (.clk_i(clk), .rst_i(rst), .bus(ifc4));

    assign ifc2.mem_rd_data_i = mem2[ifc2.mem_addr_o[9:2]];
    assign ifc3.mem_rd_data_i = mem3[ifc3.mem_addr_o[9:2]];
    assign ifc4.mem_rd_data_i = mem4[ifc4.mem_addr_o[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ifc3.mem_wr_en_o) mem3[ifc3.mem_addr_o[9:2]] = ifc3.mem_wr_data_o;
        if (ifc4.mem_wr_en_o) mem4[ifc4.mem_addr_o[9:2]] = ifc4.mem_wr_data_o;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic pop_i(output logic [31:0] v);
        if (exp_i_q.size() == 0) begin
            check_val("sb_i_empty", 32'd0, 32'd1);
            v = 'x;
        end else v = exp_i_q.pop_front();
    endtask

    task automatic pop_d(output logic [31:0] v);
        if (exp_d_q.size() == 0) begin
            check_val("sb_d_empty", 32'd0, 32'd1);
            v = 'x;
        end else v = exp_d_q.pop_front();
    endtask

    task automatic clear_if_inputs();
        ifc2.i_req_i = 0; ifc2.i_addr_i = 0; ifc2.d_req_i = 0; ifc2.d_we_i = 0;
        ifc2.d_addr_i = 0; ifc2.d_wdata_i = 0; ifc2.d_funct3_i = 0;
        ifc3.i_req_i = 0; ifc3.i_addr_i = 0; ifc3.d_req_i = 0; ifc3.d_we_i = 0;
        ifc3.d_addr_i = 0; ifc3.d_wdata_i = 0; ifc3.d_funct3_i = 0;
        ifc4.i_req_i = 0; ifc4.i_addr_i = 0; ifc4.d_req_i = 0; ifc4.d_we_i = 0;
        ifc4.d_addr_i = 0; ifc4.d_wdata_i = 0; ifc4.d_funct3_i = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_state", 32'(u2.r_state), 32'(IDLE));
        check_val("rst_i_done", 32'(ifc2.i_done_o), 32'd0);
        check_val("rst_d_done", 32'(ifc2.d_done_o), 32'd0);
        check_val("rst_i_rdata", ifc2.i_rdata_o, 32'd0);
        check_val("rst_d_rdata", ifc2.d_rdata_o, 32'd0);
        check_val("rst_mem_addr", ifc2.mem_addr_o, 32'd0);
        check_val("rst_mem_we", 32'(ifc2.mem_wr_en_o), 32'd0);
        check_val("rst_mem_wdata", ifc2.mem_wr_data_o, 32'd0);
        check_val("rst_mem_f3", 32'(ifc2.mem_funct3_o), 32'd0);
        rst  = 1'b0;
        lo_m = OWN_I;
    endtask

    task automatic test_single_read();
        int          k;
        logic [31:0] e;
        @(negedge clk);
        ifc2.i_req_i  = 1'b1;
        ifc2.i_addr_i = 32'h100;
        exp_i_q.push_back(mem2[64]);
        k = cyc;
        check_val("rd_idle_addr", ifc2.mem_addr_o, 32'd0);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            check_val("rd_busy_f3", 32'(ifc2.mem_funct3_o), 32'(FUNCT3_WORD));
            check_val("rd_busy_addr", ifc2.mem_addr_o, 32'h100);
            check_val("rd_busy_we", 32'(ifc2.mem_wr_en_o), 32'd0);
            check_val("rd_busy_nodone", 32'(ifc2.i_done_o), 32'd0);
        end
        @(negedge clk);
        check_val("rd_done_cycle", 32'(ifc2.i_done_o), 32'd1);
        check_val("rd_done_at", 32'(cyc - k), 32'd3);
        if (ifc2.i_done_o) begin
            pop_i(e);
            check_val("rd_data", ifc2.i_rdata_o, e);
            lo_m = OWN_I;
        end
        ifc2.i_req_i = 1'b0;
        @(negedge clk);
        check_val("rd_done_pulse", 32'(ifc2.i_done_o), 32'd0);
        check_val("rd_data_hold", ifc2.i_rdata_o, 32'hDEADBEEF);
    endtask

    task automatic test_write_l3();
        int k;
        int wr_cnt;
        int wr_cyc;
        int done_cyc;
        wr_cnt = 0; wr_cyc = -1; done_cyc = -1;
        @(negedge clk);
        ifc3.d_req_i = 1'b1; ifc3.d_we_i = 1'b1; ifc3.d_addr_i = 32'h40;
        ifc3.d_wdata_i = 32'h12345678; ifc3.d_funct3_i = 3'b010;
        k = cyc;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ifc3.mem_wr_en_o) begin
                wr_cnt++;
                wr_cyc = cyc;
                check_val("wr_wdata", ifc3.mem_wr_data_o, 32'h12345678);
                check_val("wr_addr", ifc3.mem_addr_o, 32'h40);
            end
            if (ifc3.d_done_o) begin
                done_cyc = cyc;
                ifc3.d_req_i = 1'b0;
                ifc3.d_we_i  = 1'b0;
            end
        end
        check_val("wr_count", 32'(wr_cnt), 32'd1);
        check_val("wr_cycle", 32'(wr_cyc - k), 32'd3);
        check_val("wr_done_cycle", 32'(done_cyc - k), 32'd4);
        check_val("wr_mem", mem3[16], 32'h12345678);
    endtask

    task automatic test_ties();
        logic [31:0] ia [3];
        logic [31:0] da [3];
        int          ii;
        int          di;
        int          prev;
        logic        got_d;
        logic        i_p;
        logic        d_p;
        logic        exp_d;
        logic [31:0] e;
        ia[0] = 32'h200; ia[1] = 32'h204; ia[2] = 32'h208;
        da[0] = 32'h300; da[1] = 32'h304; da[2] = 32'h308;
        ii = 0; di = 0; prev = -1;
        @(negedge clk);
        ifc2.i_req_i = 1'b1; ifc2.i_addr_i = ia[0];
        exp_i_q.push_back(mem2[ia[0][9:2]]);
        ifc2.d_req_i = 1'b1; ifc2.d_we_i = 1'b0; ifc2.d_funct3_i = 3'b010; ifc2.d_addr_i = da[0];
        exp_d_q.push_back(mem2[da[0][9:2]]);
        for (int c = 0; c < 80 && !(ii == 3 && di == 3); c++) begin
            @(negedge clk);
            if (ifc2.i_done_o || ifc2.d_done_o) begin
                got_d = ifc2.d_done_o;
                i_p   = got_d ? (ii < 3) : 1'b1;
                d_p   = got_d ? 1'b1 : (di < 3);
`ifdef MEM_ARB_ROUND_ROBIN_EN
                exp_d = (i_p && d_p) ? (lo_m == OWN_I) : d_p;
`else
                exp_d = d_p;
`endif
                check_val("tie_owner", 32'(got_d), 32'(exp_d));
                check_val("tie_excl", 32'(ifc2.i_done_o & ifc2.d_done_o), 32'd0);
                if (prev >= 0) check_val("tie_gap", 32'(cyc - prev), 32'd4);
                prev = cyc;
                if (got_d) begin
                    pop_d(e);
                    check_val("tie_d_data", ifc2.d_rdata_o, e);
                    lo_m = OWN_D;
                    di++;
                    if (di < 3) begin
                        ifc2.d_addr_i = da[di];
                        exp_d_q.push_back(mem2[da[di][9:2]]);
                    end else ifc2.d_req_i = 1'b0;
                end else begin
                    pop_i(e);
                    check_val("tie_i_data", ifc2.i_rdata_o, e);
                    lo_m = OWN_I;
                    ii++;
                    if (ii < 3) begin
                        ifc2.i_addr_i = ia[ii];
                        exp_i_q.push_back(mem2[ia[ii][9:2]]);
                    end else ifc2.i_req_i = 1'b0;
                end
            end
        end
        if (!(ii == 3 && di == 3)) check_val("tie_timeout", 32'(ii + di), 32'd6);
        ifc2.i_req_i = 1'b0;
        ifc2.d_req_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        int k;
        int n_we;
        int n_done;
        n_we = 0; n_done = 0;
        @(negedge clk);
        ifc4.d_req_i = 1'b1; ifc4.d_we_i = 1'b1; ifc4.d_addr_i = 32'h80;
        ifc4.d_wdata_i = 32'h0BADF00D; ifc4.d_funct3_i = 3'b010;
        k = cyc;
        @(negedge clk);
        if (ifc4.mem_wr_en_o) n_we++;
        @(negedge clk);
        check_val("rm_busy_addr", ifc4.mem_addr_o, 32'h80);
        if (ifc4.mem_wr_en_o) n_we++;
        rst = 1'b1;
        ifc4.d_req_i = 1'b0;
        ifc4.d_we_i  = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
        lo_m = OWN_I;
        check_val("rm_state", 32'(u4.r_state), 32'(IDLE));
        check_val("rm_idle_at", 32'(cyc - k), 32'd3);
        check_val("rm_mem_addr", ifc4.mem_addr_o, 32'd0);
        check_val("rm_u2_i_rdata", ifc2.i_rdata_o, 32'd0);
        check_val("rm_u2_d_rdata", ifc2.d_rdata_o, 32'd0);
        for (int c = 0; c < 8; c++) begin
            if (ifc4.mem_wr_en_o) n_we++;
            if (ifc4.d_done_o) n_done++;
            @(negedge clk);
        end
        check_val("rm_no_write", 32'(n_we), 32'd0);
        check_val("rm_no_done", 32'(n_done), 32'd0);
        check_val("rm_mem", mem4[32], 32'hA5A5A5A5);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        lo_m    = OWN_I;
        rst     = 1'b1;
        clear_if_inputs();
        for (int a = 0; a < 256; a++) begin
            mem2[a] = 32'hC0DE0000 + 32'(a * 7);
            mem3[a] = 32'd0;
            mem4[a] = 32'd0;
        end
        mem2[64] = 32'hDEADBEEF;
        mem4[32] = 32'hA5A5A5A5;

        test_reset();
        test_single_read();
        test_write_l3();
        test_ties();
        repeat (2) @(negedge clk);
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
